// File: rtl/ef_gpio_apb_n.sv
// APB GPIO block: output data/direction registers, synchronized pad inputs,
// per-pin rise/fall edge detection with sticky status, mask and level irq.
module ef_gpio_apb_n #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic [31:0]      PADDR,
  input  logic             PSEL,
  input  logic             PENABLE,
  input  logic             PWRITE,
  input  logic [31:0]      PWDATA,
  output logic [31:0]      PRDATA,
  output logic             PREADY,
  input  logic [WIDTH-1:0] io_in,
  output logic [WIDTH-1:0] io_out,
  output logic [WIDTH-1:0] io_oe,
  output logic             irq
);

  localparam int unsigned ADDR_BITS = 6;

  localparam logic [ADDR_BITS-1:0] ADDR_DATAI   = 6'h00;
  localparam logic [ADDR_BITS-1:0] ADDR_DATAO   = 6'h04;
  localparam logic [ADDR_BITS-1:0] ADDR_DIR     = 6'h08;
  localparam logic [ADDR_BITS-1:0] ADDR_RISE_EN = 6'h0C;
  localparam logic [ADDR_BITS-1:0] ADDR_FALL_EN = 6'h10;
  localparam logic [ADDR_BITS-1:0] ADDR_IM      = 6'h14;
  localparam logic [ADDR_BITS-1:0] ADDR_RIS     = 6'h18;
  localparam logic [ADDR_BITS-1:0] ADDR_MIS     = 6'h1C;
  localparam logic [ADDR_BITS-1:0] ADDR_ICR     = 6'h20;

  logic [WIDTH-1:0]     datao_q;
  logic [WIDTH-1:0]     dir_q;
  logic [WIDTH-1:0]     rise_en_q;
  logic [WIDTH-1:0]     fall_en_q;
  logic [WIDTH-1:0]     im_q;
  logic [WIDTH-1:0]     ris_q;
  logic [WIDTH-1:0]     prev_q;
  logic [WIDTH-1:0]     sync_q [SYNC_STAGES];

  logic [ADDR_BITS-1:0] addr_w;
  logic                 wr_en_w;
  logic [WIDTH-1:0]     wdata_w;
  logic [WIDTH-1:0]     sync_w;
  logic [WIDTH-1:0]     rise_w;
  logic [WIDTH-1:0]     fall_w;
  logic [WIDTH-1:0]     set_w;
  logic [WIDTH-1:0]     clr_w;
  logic [WIDTH-1:0]     mis_w;
  logic [WIDTH-1:0]     rdata_w;
  logic                 unused_bits;

  assign addr_w  = PADDR[ADDR_BITS-1:0];
  assign wr_en_w = PSEL & PENABLE & PWRITE;
  assign wdata_w = PWDATA[WIDTH-1:0];

  // Upper address bits and (for narrow instances) upper write data are don't-care.
  assign unused_bits = ^{PADDR[31:ADDR_BITS], PWDATA};

  // Metastability chain for the asynchronous pad inputs.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= io_in;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign sync_w = sync_q[SYNC_STAGES-1];
  assign rise_w = sync_w & ~prev_q;
  assign fall_w = ~sync_w & prev_q;
  assign set_w  = (rise_w & rise_en_q) | (fall_w & fall_en_q);
  assign clr_w  = (wr_en_w && (addr_w == ADDR_ICR)) ? wdata_w : '0;
  assign mis_w  = ris_q & im_q;

  // Control registers, edge history and sticky status; a new event beats an ICR clear.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      datao_q   <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      im_q      <= '0;
      ris_q     <= '0;
      prev_q    <= '0;
    end else begin
      if (wr_en_w) begin
        case (addr_w)
          ADDR_DATAO:   datao_q   <= wdata_w;
          ADDR_DIR:     dir_q     <= wdata_w;
          ADDR_RISE_EN: rise_en_q <= wdata_w;
          ADDR_FALL_EN: fall_en_q <= wdata_w;
          ADDR_IM:      im_q      <= wdata_w;
          default:      ;
        endcase
      end
      prev_q <= sync_w;
      ris_q  <= (ris_q & ~clr_w) | set_w;
    end
  end

  // Combinational read mux; only live during a selected read.
  always_comb begin
    rdata_w = '0;
    if (PSEL && !PWRITE) begin
      case (addr_w)
        ADDR_DATAI:   rdata_w = sync_w;
        ADDR_DATAO:   rdata_w = datao_q;
        ADDR_DIR:     rdata_w = dir_q;
        ADDR_RISE_EN: rdata_w = rise_en_q;
        ADDR_FALL_EN: rdata_w = fall_en_q;
        ADDR_IM:      rdata_w = im_q;
        ADDR_RIS:     rdata_w = ris_q;
        ADDR_MIS:     rdata_w = mis_w;
        default:      rdata_w = '0;
      endcase
    end
  end

  assign PRDATA = 32'(rdata_w);
  assign PREADY = 1'b1;
  assign io_out = datao_q;
  assign io_oe  = dir_q;
  assign irq    = |mis_w;

endmodule

// File: tb/tb_ef_gpio_apb_n.sv
// Directed bench for ef_gpio_apb_n: register table plus edge/irq/reset sequences.
module tb_ef_gpio_apb_n;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [31:0] PADDR;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PWDATA, PRDATA;
  logic        PREADY;
  logic [7:0]  io_in, io_out, io_oe;
  logic        irq;

  logic [31:0] p32_paddr, p32_pwdata, p32_prdata;
  logic        p32_psel, p32_penable, p32_pwrite, p32_pready, p32_irq;
  logic [31:0] io_in32, io_out32, io_oe32;

  int checks = 0;
  int errors = 0;

  ef_gpio_apb_n #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .io_in(io_in), .io_out(io_out), .io_oe(io_oe), .irq(irq)
  );

  ef_gpio_apb_n #(.WIDTH(32), .SYNC_STAGES(2)) dut32 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(p32_paddr), .PSEL(p32_psel),
    .PENABLE(p32_penable), .PWRITE(p32_pwrite), .PWDATA(p32_pwdata),
    .PRDATA(p32_prdata), .PREADY(p32_pready), .io_in(io_in32),
    .io_out(io_out32), .io_oe(io_oe32), .irq(p32_irq)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    string       name;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    logic [7:0]  exp_out;
    logic [7:0]  exp_oe;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Commits on the second rising edge after the call.
  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    PADDR = a; PWDATA = d; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
    tick();
    PENABLE = 1'b1;
    tick();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    PADDR = a; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
    #1 d = PRDATA;
    PSEL = 1'b0;
    #1;
  endtask

  logic [31:0] rd;

  initial begin
    vecs[0]  = '{"w_datao",     1'b1, 32'h04,        32'h0000_00A5, 32'h0, 8'hA5, 8'h00};
    vecs[1]  = '{"w_dir",       1'b1, 32'h08,        32'h0000_00F0, 32'h0, 8'hA5, 8'hF0};
    vecs[2]  = '{"r_datao",     1'b0, 32'h04,        32'h0,         32'h0000_00A5, 8'hA5, 8'hF0};
    vecs[3]  = '{"r_dir",       1'b0, 32'h08,        32'h0,         32'h0000_00F0, 8'hA5, 8'hF0};
    vecs[4]  = '{"w_datao_hi",  1'b1, 32'h04,        32'hFFFF_FF3C, 32'h0, 8'h3C, 8'hF0};
    vecs[5]  = '{"r_datao_hi",  1'b0, 32'h04,        32'h0,         32'h0000_003C, 8'h3C, 8'hF0};
    vecs[6]  = '{"r_dir_upaddr",1'b0, 32'hFFFF_FF08, 32'h0,         32'h0000_00F0, 8'h3C, 8'hF0};
    vecs[7]  = '{"w_unmapped",  1'b1, 32'h24,        32'h0000_00FF, 32'h0, 8'h3C, 8'hF0};
    vecs[8]  = '{"r_unmapped",  1'b0, 32'h24,        32'h0,         32'h0, 8'h3C, 8'hF0};
    vecs[9]  = '{"r_icr",       1'b0, 32'h20,        32'h0,         32'h0, 8'h3C, 8'hF0};
    vecs[10] = '{"w_im",        1'b1, 32'h14,        32'h0000_0055, 32'h0, 8'h3C, 8'hF0};
    vecs[11] = '{"r_im",        1'b0, 32'h14,        32'h0,         32'h0000_0055, 8'h3C, 8'hF0};
    vecs[12] = '{"r_unaligned", 1'b0, 32'h05,        32'h0,         32'h0, 8'h3C, 8'hF0};
    vecs[13] = '{"w_datao_rst", 1'b1, 32'h04,        32'h0000_00A5, 32'h0, 8'hA5, 8'hF0};

    PRESETn = 1'b0; PADDR = '0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PWDATA = '0;
    io_in = '0; io_in32 = '0;
    p32_paddr = '0; p32_pwdata = '0; p32_psel = 1'b0; p32_penable = 1'b0; p32_pwrite = 1'b0;
    #1;
    chk("rst_io_out", 32'(io_out), 32'h0);
    chk("rst_io_oe", 32'(io_oe), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_prdata", PRDATA, 32'h0);
    chk("rst_pready", 32'(PREADY), 32'h1);
    tick(); tick();
    PRESETn = 1'b1;
    tick();
    for (int a = 0; a <= 32; a += 4) begin
      peek(32'(a), rd);
      chk($sformatf("rst_reg_%02h", a), rd, 32'h0);
    end

    // Register table
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].wr) begin
        apb_write(vecs[i].addr, vecs[i].data);
      end else begin
        peek(vecs[i].addr, rd);
        chk(vecs[i].name, rd, vecs[i].exp_rd);
      end
      chk({vecs[i].name, "/io_out"}, 32'(io_out), 32'(vecs[i].exp_out));
      chk({vecs[i].name, "/io_oe"}, 32'(io_oe), 32'(vecs[i].exp_oe));
    end
    apb_write(32'h14, 32'h0);

    // Synchronized input readback
    io_in = 8'h96;
    tick(); tick(); tick();
    peek(32'h00, rd);
    chk("datai", rd, 32'h96);
    io_in = 8'h00;
    tick(); tick(); tick();

    // Rise on pin 0 reaches RIS/irq exactly three edges later
    apb_write(32'h0C, 32'h01);
    apb_write(32'h14, 32'h01);
    io_in[0] = 1'b1;
    tick(); chk("lat_edge1_irq", 32'(irq), 32'h0);
    tick(); chk("lat_edge2_irq", 32'(irq), 32'h0);
    tick(); chk("lat_edge3_irq", 32'(irq), 32'h1);
    peek(32'h18, rd); chk("lat_ris", rd, 32'h01);
    peek(32'h1C, rd); chk("lat_mis", rd, 32'h01);

    apb_write(32'h20, 32'h01);
    chk("icr_irq", 32'(irq), 32'h0);
    peek(32'h18, rd); chk("icr_ris", rd, 32'h0);

    // Fall on pin 0 with FALL_EN clear does nothing
    io_in[0] = 1'b0;
    repeat (5) tick();
    peek(32'h18, rd); chk("fall_ignored_ris", rd, 32'h0);
    chk("fall_ignored_irq", 32'(irq), 32'h0);

    // New rise lands on the same edge as the ICR clear: set wins
    io_in[0] = 1'b1;
    tick();
    apb_write(32'h20, 32'h01);
    peek(32'h18, rd); chk("set_beats_clr_ris", rd, 32'h01);
    chk("set_beats_clr_irq", 32'(irq), 32'h1);
    apb_write(32'h20, 32'hFF);
    peek(32'h18, rd); chk("clr_all_ris", rd, 32'h0);

    // Masked event on pin 3, then unmask without a new edge
    apb_write(32'h14, 32'h00);
    apb_write(32'h0C, 32'h08);
    io_in[3] = 1'b1;
    repeat (4) tick();
    peek(32'h18, rd); chk("masked_ris", rd, 32'h08);
    peek(32'h1C, rd); chk("masked_mis", rd, 32'h00);
    chk("masked_irq", 32'(irq), 32'h0);
    apb_write(32'h14, 32'h08);
    chk("unmask_irq", 32'(irq), 32'h1);
    peek(32'h1C, rd); chk("unmask_mis", rd, 32'h08);

    // Output-direction pin 4 is still monitored
    apb_write(32'h0C, 32'h18);
    io_in[4] = 1'b1;
    repeat (4) tick();
    peek(32'h18, rd); chk("outpin_ris", rd, 32'h18);

    // Unmapped read, RO writes ignored
    peek(32'h24, rd); chk("r_0x24", rd, 32'h0);
    apb_write(32'h18, 32'h00);
    apb_write(32'h1C, 32'h00);
    peek(32'h18, rd); chk("ris_after_ro_write", rd, 32'h18);

    // Setup phase without PENABLE commits nothing; PSEL=0 reads zero
    PADDR = 32'h04; PWDATA = 32'h00; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
    tick(); tick();
    PSEL = 1'b0; PWRITE = 1'b0;
    chk("no_penable_io_out", 32'(io_out), 32'hA5);
    #1 chk("psel0_prdata", PRDATA, 32'h0);

    // 32-bit instance full-width readback
    p32_paddr = 32'h04; p32_pwdata = 32'hFFFF_FFFF; p32_pwrite = 1'b1; p32_psel = 1'b1; p32_penable = 1'b0;
    tick();
    p32_penable = 1'b1;
    tick();
    p32_penable = 1'b0; p32_pwrite = 1'b0;
    #1 chk("w32_readback", p32_prdata, 32'hFFFF_FFFF);
    chk("w32_io_out", io_out32, 32'hFFFF_FFFF);
    p32_psel = 1'b0;

    // Async reset mid-transfer with everything nonzero and irq high
    chk("pre_rst_irq", 32'(irq), 32'h1);
    PADDR = 32'h04; PWDATA = 32'h11; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
    #2 PRESETn = 1'b0;
    #1;
    chk("arst_io_out", 32'(io_out), 32'h0);
    chk("arst_io_oe", 32'(io_oe), 32'h0);
    chk("arst_irq", 32'(irq), 32'h0);
    chk("arst_pready", 32'(PREADY), 32'h1);
    chk("arst_io_out32", io_out32, 32'h0);
    PSEL = 1'b0; PWRITE = 1'b0;
    #1 chk("arst_prdata", PRDATA, 32'h0);
    peek(32'h18, rd); chk("arst_ris", rd, 32'h0);
    peek(32'h00, rd); chk("arst_datai", rd, 32'h0);
    tick();
    PRESETn = 1'b1;
    tick(); tick();
    peek(32'h04, rd); chk("post_rst_datao", rd, 32'h0);
    peek(32'h14, rd); chk("post_rst_im", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
